// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch hazard stall, redirect sequencing and perf counters
module branch_hazard_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_branch_type,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest,
  input  logic             mem_wb_en,
  input  logic [4:0]       mem_dest,
  input  logic             branch_taken,
  output logic             freeze,
  output logic             id_ex_bubble,
  output logic             pc_src,
  output logic             if_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] taken_count,
  output logic             hazard_timeout
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] HOLD     = 2'b01;
  localparam logic [1:0] REDIRECT = 2'b10;
  localparam int         HC_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(MAX_HOLD - 1);

  logic [1:0]      next_state;
  logic [HC_W-1:0] hold_cnt;
  logic            is_br, rd1, rd2, br_haz, nb_haz, haz, resolve;

  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] d);
    return (r != 5'd0) && (r == d);
  endfunction

  // Branches compare in ID with no forwarding, so both EX and MEM producers stall them.
  always_comb begin
    is_br   = id_valid && (id_branch_type != 2'b00);
    rd1     = (id_branch_type == 2'b01) || (id_branch_type == 2'b10);
    rd2     = (id_branch_type == 2'b10);
    br_haz  = is_br &&
              ((rd1 && ((ex_wb_en && reg_match(id_src1, ex_dest)) ||
                        (mem_wb_en && reg_match(id_src1, mem_dest)))) ||
               (rd2 && ((ex_wb_en && reg_match(id_src2, ex_dest)) ||
                        (mem_wb_en && reg_match(id_src2, mem_dest)))));
    nb_haz  = id_valid && !is_br && ex_wb_en && ex_mem_read &&
              ((id_use_src1 && reg_match(id_src1, ex_dest)) ||
               (id_use_src2 && reg_match(id_src2, ex_dest)));
    haz     = br_haz || nb_haz;
    resolve = is_br && !haz && (branch_taken || (id_branch_type == 2'b11));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = RUN;
    case (state)
      RUN, HOLD: begin
        if (haz)          next_state = HOLD;
        else if (resolve) next_state = REDIRECT;
        else              next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // REDIRECT holds the flushed bubble, so its inputs are ignored.
  always_comb begin
    freeze       = 1'b0;
    id_ex_bubble = 1'b0;
    pc_src       = 1'b0;
    if_flush     = 1'b0;
    if (!rst && (state == RUN || state == HOLD)) begin
      freeze       = haz;
      id_ex_bubble = haz;
      pc_src       = resolve;
      if_flush     = resolve;
    end
  end

  // hold_cnt counts consecutive frozen cycles, including the RUN cycle that entered HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt       <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      if (freeze) begin
        if (hold_cnt != HC_LAST) hold_cnt <= hold_cnt + HC_W'(1);
        if (hold_cnt == HC_LAST) hazard_timeout <= 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      taken_count <= '0;
    end else begin
      if (freeze && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
      if (pc_src && taken_count != {CNT_W{1'b1}}) taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - scoreboard bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [1:0] RUN = 2'b00, HOLD = 2'b01, REDIR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, id_use_src1, id_use_src2, ex_wb_en, ex_mem_read, mem_wb_en, branch_taken;
  logic [1:0] id_branch_type;
  logic [4:0] id_src1, id_src2, ex_dest, mem_dest;
  logic freeze, id_ex_bubble, pc_src, if_flush, hazard_timeout;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_count, taken_count;

  typedef struct {
    logic f, b, p, fl, to;
    logic [1:0] st;
    logic [CNT_W-1:0] sc, tc;
  } exp_t;

  exp_t exp_q[$];
  logic [CNT_W-1:0] exp_stall = '0, exp_taken = '0;
  logic exp_to = 1'b0;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.MAX_HOLD(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch_type(id_branch_type),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_src1(id_src1), .id_src2(id_src2),
    .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
    .freeze(freeze), .id_ex_bubble(id_ex_bubble), .pc_src(pc_src), .if_flush(if_flush),
    .state(state), .stall_count(stall_count), .taken_count(taken_count),
    .hazard_timeout(hazard_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_branch_type = 2'b00; id_use_src1 = 0; id_use_src2 = 0;
    id_src1 = 0; id_src2 = 0; ex_wb_en = 0; ex_mem_read = 0; ex_dest = 0;
    mem_wb_en = 0; mem_dest = 0; branch_taken = 0;
  endtask

  task automatic branch(input logic [1:0] t, input logic [4:0] s1, input logic [4:0] s2, input logic tk);
    id_valid = 1; id_branch_type = t; id_src1 = s1; id_src2 = s2; branch_taken = tk;
  endtask

  // Inputs already driven; push expectation, compare mid low phase, then advance one clock.
  task automatic cyc(input string tag, input logic f, input logic b, input logic p,
                     input logic fl, input logic [1:0] st);
    exp_t e;
    exp_t g;
    e.f = f; e.b = b; e.p = p; e.fl = fl; e.st = st;
    e.to = exp_to; e.sc = exp_stall; e.tc = exp_taken;
    exp_q.push_back(e);
    #2;
    g = exp_q.pop_front();
    check({tag, ".freeze"}, 32'(freeze), 32'(g.f));
    check({tag, ".bubble"}, 32'(id_ex_bubble), 32'(g.b));
    check({tag, ".pc_src"}, 32'(pc_src), 32'(g.p));
    check({tag, ".if_flush"}, 32'(if_flush), 32'(g.fl));
    check({tag, ".state"}, 32'(state), 32'(g.st));
    check({tag, ".stall_count"}, 32'(stall_count), 32'(g.sc));
    check({tag, ".taken_count"}, 32'(taken_count), 32'(g.tc));
    check({tag, ".timeout"}, 32'(hazard_timeout), 32'(g.to));
    @(posedge clk);
    if (!rst) begin
      if (g.f && exp_stall != CMAX) exp_stall++;
      if (g.p && exp_taken != CMAX) exp_taken++;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    #2 rst = 1;
    @(negedge clk);
    // Hazard inputs during reset must not reach the command outputs.
    branch(2'b01, 5'd5, 5'd0, 1'b1); ex_wb_en = 1; ex_dest = 5'd5;
    cyc("rst_force", 0, 0, 0, 0, RUN);
    idle_inputs();
    rst = 0;
    for (int i = 0; i < 5; i++) cyc("idle", 0, 0, 0, 0, RUN);

    // BEZ through EX then MEM, then taken.
    branch(2'b01, 5'd5, 5'd0, 1'b1); ex_wb_en = 1; ex_dest = 5'd5;
    cyc("bez_ex", 1, 1, 0, 0, RUN);
    ex_wb_en = 0; ex_dest = 0; mem_wb_en = 1; mem_dest = 5'd5;
    cyc("bez_mem", 1, 1, 0, 0, HOLD);
    mem_wb_en = 0; mem_dest = 0;
    cyc("bez_take", 0, 0, 1, 1, HOLD);
    ex_wb_en = 1; ex_dest = 5'd5;
    cyc("bez_redir", 0, 0, 0, 0, REDIR);
    idle_inputs();
    cyc("bez_run", 0, 0, 0, 0, RUN);
    check("bez_stalls", 32'(exp_stall), 32'd2);
    check("bez_taken", 32'(exp_taken), 32'd1);

    // Register 0 never matches; jump ignores operands.
    branch(2'b10, 5'd0, 5'd0, 1'b0); ex_wb_en = 1; ex_dest = 5'd0;
    cyc("bne_r0", 0, 0, 0, 0, RUN);
    branch(2'b11, 5'd3, 5'd3, 1'b0); ex_wb_en = 1; ex_dest = 5'd3;
    cyc("jump", 0, 0, 1, 1, RUN);
    cyc("jump_redir", 0, 0, 0, 0, REDIR);
    idle_inputs();

    // BNE src2 hazard from MEM, resolves not taken.
    branch(2'b10, 5'd1, 5'd9, 1'b0); mem_wb_en = 1; mem_dest = 5'd9;
    cyc("bne_mem", 1, 1, 0, 0, RUN);
    mem_wb_en = 0;
    cyc("bne_nt", 0, 0, 0, 0, HOLD);
    idle_inputs();
    cyc("bne_run", 0, 0, 0, 0, RUN);

    // Load-use on a non-branch: MEM producers do not stall it.
    id_valid = 1; id_use_src2 = 1; id_src2 = 5'd7; ex_wb_en = 1; ex_mem_read = 1; ex_dest = 5'd7;
    cyc("lu_stall", 1, 1, 0, 0, RUN);
    ex_wb_en = 0; ex_mem_read = 0; ex_dest = 0; mem_wb_en = 1; mem_dest = 5'd7;
    cyc("lu_clear", 0, 0, 0, 0, HOLD);
    mem_wb_en = 0; ex_wb_en = 1; ex_dest = 5'd7;
    cyc("lu_noread", 0, 0, 0, 0, RUN);
    ex_mem_read = 1; id_use_src2 = 0;
    cyc("lu_unused", 0, 0, 0, 0, RUN);
    idle_inputs();

    // Watchdog: 7 frozen cycles stay silent, 8 trip it.
    branch(2'b01, 5'd4, 5'd0, 1'b0); ex_wb_en = 1; ex_dest = 5'd4;
    for (int i = 0; i < 7; i++) cyc("wd7", 1, 1, 0, 0, (i == 0) ? RUN : HOLD);
    ex_wb_en = 0;
    cyc("wd7_exit", 0, 0, 0, 0, HOLD);
    ex_wb_en = 1;
    for (int i = 0; i < 8; i++) cyc("wd8", 1, 1, 0, 0, (i == 0) ? RUN : HOLD);
    exp_to = 1'b1;
    ex_wb_en = 0;
    cyc("wd8_exit", 0, 0, 0, 0, HOLD);
    idle_inputs();
    cyc("wd_sticky", 0, 0, 0, 0, RUN);

    // Saturation: hold a hazard for 2^CNT_W+3 cycles.
    branch(2'b01, 5'd4, 5'd0, 1'b0); ex_wb_en = 1; ex_dest = 5'd4;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc("sat", 1, 1, 0, 0, (i == 0) ? RUN : HOLD);
    check("sat_model", 32'(exp_stall), 32'(CMAX));

    // Asynchronous reset mid-HOLD.
    #1 rst = 1;
    exp_stall = '0; exp_taken = '0; exp_to = 1'b0;
    #1 check("rst_async_state", 32'(state), 32'(RUN));
    check("rst_async_freeze", 32'(freeze), 32'd0);
    @(negedge clk);
    cyc("rst_hold", 0, 0, 0, 0, RUN);
    rst = 0;
    cyc("post_rst", 1, 1, 0, 0, RUN);
    idle_inputs();
    cyc("post_rst_clr", 0, 0, 0, 0, HOLD);
    cyc("final", 0, 0, 0, 0, RUN);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
